// File: rtl/otter_fetch_stage.sv
// OTTER instruction-fetch stage: PC register, next-PC selection and a single-outstanding
// imem handshake. Define FETCH_BYPASS_EN to forward imem responses straight to Instr_F.
module otter_fetch_stage #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR    = 32'h0000_0013
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        stall_F,
  input  logic        PCSrc_E,
  input  logic [31:0] PC_target_E,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_valid,
  output logic [31:0] Instr_F,
  output logic [31:0] PC_F,
  output logic [31:0] PC_plus4_F,
  output logic        fetch_valid_F
);

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_DROP
  } state_t;

  state_t      state;
  logic [31:0] pc_q;
  logic [31:0] buf_q;
  logic [31:0] pc_plus4;
  logic [31:0] target_aligned;
  logic        bypass_take;
  logic        advance;

  assign pc_plus4       = pc_q + 32'd4;
  assign target_aligned = {PC_target_E[31:2], 2'b00};

`ifdef FETCH_BYPASS_EN
  // A response arriving in WAIT is presented directly unless a redirect kills it.
  assign bypass_take = (state == S_WAIT) && imem_valid && !PCSrc_E;
`else
  assign bypass_take = 1'b0;
`endif

  // The presented instruction is consumed this edge and the next sequential fetch goes out.
  assign advance = ((state == S_HOLD) && !stall_F && !PCSrc_E) || (bypass_take && !stall_F);

  assign imem_req      = RST_N && ((state == S_REQ) || advance);
  assign imem_addr     = (state == S_REQ) ? pc_q : pc_plus4;
  assign fetch_valid_F = (state == S_HOLD) || bypass_take;
  assign Instr_F       = (state == S_HOLD) ? buf_q :
                         bypass_take       ? imem_rdata : NOP_INSTR;
  assign PC_F          = pc_q;
  assign PC_plus4_F    = pc_plus4;

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state <= S_REQ;
      pc_q  <= RESET_VECTOR;
      buf_q <= '0;
    end else begin
      case (state)
        S_REQ: begin
          if (PCSrc_E) begin
            pc_q  <= target_aligned;
            state <= S_DROP;
          end else begin
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (PCSrc_E) begin
            pc_q  <= target_aligned;
            state <= imem_valid ? S_REQ : S_DROP;
          end else if (imem_valid) begin
            if (advance) begin
              pc_q <= pc_plus4;
            end else begin
              buf_q <= imem_rdata;
              state <= S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (PCSrc_E) begin
            pc_q  <= target_aligned;
            state <= S_REQ;
          end else if (advance) begin
            pc_q  <= pc_plus4;
            state <= S_WAIT;
          end
        end
        S_DROP: begin
          if (PCSrc_E) pc_q <= target_aligned;
          // The stale response closes the drop window; a fresh fetch can then be issued.
          if (imem_valid) state <= S_REQ;
        end
        default: state <= S_REQ;
      endcase
    end
  end

endmodule

// File: tb/tb_otter_fetch_stage.sv
// Cycle-by-cycle vector bench for otter_fetch_stage with a latency-programmable imem model
// that returns the request address as the instruction word.
module tb_otter_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        stall_F;
  logic        PCSrc_E;
  logic [31:0] PC_target_E;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_valid;
  logic [31:0] Instr_F;
  logic [31:0] PC_F;
  logic [31:0] PC_plus4_F;
  logic        fetch_valid_F;

  int total = 0;
  int bad   = 0;
  int lat   = 1;

  otter_fetch_stage dut (
    .CLK          (CLK),
    .RST_N        (RST_N),
    .stall_F      (stall_F),
    .PCSrc_E      (PCSrc_E),
    .PC_target_E  (PC_target_E),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_rdata   (imem_rdata),
    .imem_valid   (imem_valid),
    .Instr_F      (Instr_F),
    .PC_F         (PC_F),
    .PC_plus4_F   (PC_plus4_F),
    .fetch_valid_F(fetch_valid_F)
  );

  always #5 CLK = ~CLK;

  // Instruction memory: response pulse 'lat' cycles after the request is sampled.
  logic        pend;
  logic [31:0] pend_addr;
  int          pend_cnt;
  always @(posedge CLK) begin
    if (!RST_N) begin
      pend       <= 1'b0;
      imem_valid <= 1'b0;
      imem_rdata <= '0;
    end else begin
      imem_valid <= 1'b0;
      if (imem_req && lat == 1) begin
        imem_valid <= 1'b1;
        imem_rdata <= imem_addr;
        pend       <= 1'b0;
      end else if (imem_req) begin
        pend      <= 1'b1;
        pend_addr <= imem_addr;
        pend_cnt  <= lat - 1;
      end else if (pend) begin
        if (pend_cnt == 1) begin
          imem_valid <= 1'b1;
          imem_rdata <= pend_addr;
          pend       <= 1'b0;
        end else begin
          pend_cnt <= pend_cnt - 1;
        end
      end
    end
  end

  typedef struct {
    logic        stall;
    logic        pcsrc;
    logic [31:0] tgt;
    int          lat;
    logic        fv;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        req;
    logic [31:0] addr;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(logic s, logic p, logic [31:0] t, int l, logic fv,
                              logic [31:0] ins, logic [31:0] pc, logic r, logic [31:0] a);
    vec_t v;
    v.stall = s; v.pcsrc = p; v.tgt = t; v.lat = l; v.fv = fv;
    v.instr = ins; v.pc = pc; v.req = r; v.addr = a;
    vecs.push_back(v);
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    // Columns: stall, pcsrc, target, latency | fetch_valid, Instr_F, PC_F, imem_req, imem_addr
`ifdef FETCH_BYPASS_EN
    add(0, 0, 0, 1,  0, NOP,      32'h00, 1, 32'h00);
    add(0, 0, 0, 1,  1, 32'h00,   32'h00, 1, 32'h04);
    add(0, 0, 0, 1,  1, 32'h04,   32'h04, 1, 32'h08);
    add(0, 0, 0, 1,  1, 32'h08,   32'h08, 1, 32'h0C);
    add(0, 0, 0, 1,  1, 32'h0C,   32'h0C, 1, 32'h10);
    add(1, 0, 0, 1,  1, 32'h10,   32'h10, 0, 32'h00);
    add(0, 0, 0, 1,  1, 32'h10,   32'h10, 1, 32'h14);
    add(0, 0, 0, 3,  1, 32'h14,   32'h14, 1, 32'h18);
`else
    add(0, 0, 0, 1,  0, NOP,      32'h00, 1, 32'h00);
    add(0, 0, 0, 1,  0, NOP,      32'h00, 0, 32'h00);
    add(0, 0, 0, 1,  1, 32'h00,   32'h00, 1, 32'h04);
    add(0, 0, 0, 1,  0, NOP,      32'h04, 0, 32'h00);
    add(0, 0, 0, 1,  1, 32'h04,   32'h04, 1, 32'h08);
    add(0, 0, 0, 1,  0, NOP,      32'h08, 0, 32'h00);
    add(1, 0, 0, 1,  1, 32'h08,   32'h08, 0, 32'h00);
    add(1, 0, 0, 1,  1, 32'h08,   32'h08, 0, 32'h00);
    add(1, 0, 0, 1,  1, 32'h08,   32'h08, 0, 32'h00);
    add(0, 0, 0, 1,  1, 32'h08,   32'h08, 1, 32'h0C);
    add(0, 0, 0, 1,  0, NOP,      32'h0C, 0, 32'h00);
    add(1, 1, 32'h103, 1, 1, 32'h0C, 32'h0C, 0, 32'h00);
    add(0, 0, 0, 1,  0, NOP,      32'h100, 1, 32'h100);
    add(0, 0, 0, 1,  0, NOP,      32'h100, 0, 32'h00);
    add(0, 0, 0, 1,  1, 32'h100,  32'h100, 1, 32'h104);
    add(0, 0, 0, 1,  0, NOP,      32'h104, 0, 32'h00);
    add(0, 1, 32'h10, 3, 1, 32'h104, 32'h104, 0, 32'h00);
    add(0, 0, 0, 3,  0, NOP,      32'h10, 1, 32'h10);
    add(0, 1, 32'h103, 3, 0, NOP, 32'h10, 0, 32'h00);
    add(0, 0, 0, 3,  0, NOP,      32'h100, 0, 32'h00);
    add(0, 0, 0, 3,  0, NOP,      32'h100, 0, 32'h00);
    add(0, 0, 0, 3,  0, NOP,      32'h100, 1, 32'h100);
    add(0, 0, 0, 3,  0, NOP,      32'h100, 0, 32'h00);
    add(0, 0, 0, 3,  0, NOP,      32'h100, 0, 32'h00);
    add(0, 0, 0, 3,  0, NOP,      32'h100, 0, 32'h00);
    add(0, 1, 32'hFFFF_FFFF, 1, 1, 32'h100, 32'h100, 0, 32'h00);
    add(0, 0, 0, 1,  0, NOP, 32'hFFFF_FFFC, 1, 32'hFFFF_FFFC);
    add(0, 0, 0, 1,  0, NOP, 32'hFFFF_FFFC, 0, 32'h00);
    add(0, 0, 0, 1,  1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1, 32'h00);
    add(0, 0, 0, 1,  0, NOP,      32'h00, 0, 32'h00);
    add(0, 0, 0, 1,  1, 32'h00,   32'h00, 1, 32'h04);
    add(0, 1, 32'h200, 1, 0, NOP, 32'h04, 0, 32'h00);
    add(0, 1, 32'h300, 1, 0, NOP, 32'h200, 1, 32'h200);
    add(0, 0, 0, 1,  0, NOP,      32'h300, 0, 32'h00);
    add(0, 0, 0, 1,  0, NOP,      32'h300, 1, 32'h300);
    add(0, 0, 0, 1,  0, NOP,      32'h300, 0, 32'h00);
    add(0, 0, 0, 3,  1, 32'h300,  32'h300, 1, 32'h304);
`endif

    RST_N = 1'b0; stall_F = 1'b0; PCSrc_E = 1'b0; PC_target_E = '0; lat = 1;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    #1;
    check("reset PC_F", PC_F, 32'h0);
    check("reset PC_plus4_F", PC_plus4_F, 32'h4);
    check("reset imem_req gated", {31'b0, imem_req}, 32'h0);
    check("reset fetch_valid_F", {31'b0, fetch_valid_F}, 32'h0);
    check("reset Instr_F", Instr_F, NOP);
    RST_N = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      stall_F = vecs[i].stall;
      PCSrc_E = vecs[i].pcsrc;
      PC_target_E = vecs[i].tgt;
      lat = vecs[i].lat;
      #1;
      check($sformatf("v%0d fetch_valid_F", i), {31'b0, fetch_valid_F}, {31'b0, vecs[i].fv});
      check($sformatf("v%0d Instr_F", i), Instr_F, vecs[i].instr);
      check($sformatf("v%0d PC_F", i), PC_F, vecs[i].pc);
      check($sformatf("v%0d PC_plus4_F", i), PC_plus4_F, vecs[i].pc + 32'd4);
      check($sformatf("v%0d imem_req", i), {31'b0, imem_req}, {31'b0, vecs[i].req});
      if (vecs[i].req)
        check($sformatf("v%0d imem_addr", i), imem_addr, vecs[i].addr);
      @(negedge CLK);
    end

    // Reset while a 3-cycle fetch is outstanding: the stale response must never appear.
    stall_F = 1'b0; PCSrc_E = 1'b0; lat = 3;
    RST_N = 1'b0;
    #1;
    check("midreset imem_req gated", {31'b0, imem_req}, 32'h0);
    @(negedge CLK);
    RST_N = 1'b1;
    #1;
    check("postreset PC_F", PC_F, 32'h0);
    check("postreset imem_req", {31'b0, imem_req}, 32'h1);
    check("postreset imem_addr", imem_addr, 32'h0);
    check("postreset fetch_valid_F", {31'b0, fetch_valid_F}, 32'h0);
    repeat (2) begin
      @(negedge CLK);
      #1;
      check("postreset wait no stale valid", {31'b0, fetch_valid_F}, 32'h0);
    end
    @(negedge CLK);
    #1;
`ifdef FETCH_BYPASS_EN
    check("postreset bypass fetch_valid_F", {31'b0, fetch_valid_F}, 32'h1);
    check("postreset bypass Instr_F", Instr_F, 32'h0);
`else
    check("postreset wait fetch_valid_F", {31'b0, fetch_valid_F}, 32'h0);
    @(negedge CLK);
    #1;
    check("postreset hold fetch_valid_F", {31'b0, fetch_valid_F}, 32'h1);
    check("postreset hold Instr_F", Instr_F, 32'h0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
